// File: rtl/la_ioshortbus_pkg.sv
// Shared types and helpers for the la_ioshortbus multi-channel bidirectional short.
package la_ioshortbus_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_TURN = 2'd1,
      ST_A2B  = 2'd2,
      ST_B2A  = 2'd3
   } state_e;

   function automatic int cnt_width(input int turn);
      return (turn < 1) ? 1 : $clog2(turn + 1);
   endfunction

endpackage

// File: rtl/la_ioshortbus_ch.sv
// One break-before-make channel: FSM, turnaround down-counter and the tristate
// drivers for its a/b pair. At most one side is ever enabled.
//
// state   | meaning
// --------+------------------------------------------------------
// ST_OFF  | disabled, both sides released
// ST_TURN | turnaround, both sides released while cnt_q runs down
// ST_A2B  | committed, b follows a
// ST_B2A  | committed, a follows b
module la_ioshortbus_ch
   import la_ioshortbus_pkg::*;
#(
   parameter int TURN = 2
) (
   input  logic clk,
   input  logic nreset,
   inout  wire  a,
   inout  wire  b,
   input  logic a2b,
   input  logic en,
   output logic dir,
   output logic act,
   output logic busy
);

   localparam int            CW   = cnt_width(TURN);
   localparam logic [CW-1:0] LOAD = CW'(TURN - 1);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          dir_q;
   logic          act_q;
   logic          busy_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         act_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else if (!en) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         act_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_q <= ST_TURN;
               cnt_q   <= LOAD;
               act_q   <= 1'b0;
               busy_q  <= 1'b1;
            end
            ST_TURN: begin
               // request changes here never reload; the value at the final edge wins
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  state_q <= a2b ? ST_A2B : ST_B2A;
                  dir_q   <= a2b;
                  act_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            ST_A2B, ST_B2A: begin
               if (a2b != dir_q) begin
                  state_q <= ST_TURN;
                  cnt_q   <= LOAD;
                  act_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_OFF;
               cnt_q   <= '0;
               act_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign b = (state_q == ST_A2B) ? a : 1'bz;
   assign a = (state_q == ST_B2A) ? b : 1'bz;

   assign dir  = dir_q;
   assign act  = act_q;
   assign busy = busy_q;

endmodule

// File: rtl/la_ioshortbus.sv
// N-channel break-before-make bidirectional short between a[] and b[].
// Define LA_IOSHORTBUS_SYNC_EN to pass a2b/en through two-flop synchronisers.
module la_ioshortbus
   import la_ioshortbus_pkg::*;
#(
   parameter int N    = 8,
   parameter int TURN = 2
) (
   input  logic         clk,
   input  logic         nreset,
   inout  wire  [N-1:0] a,
   inout  wire  [N-1:0] b,
   input  logic [N-1:0] a2b,
   input  logic         en,
   output logic [N-1:0] dir,
   output logic [N-1:0] act,
   output logic [N-1:0] busy
);

   logic [N-1:0] a2b_c;
   logic         en_c;

`ifdef LA_IOSHORTBUS_SYNC_EN
   logic [N-1:0] a2b_s1_q;
   logic [N-1:0] a2b_s2_q;
   logic         en_s1_q;
   logic         en_s2_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         a2b_s1_q <= '0;
         a2b_s2_q <= '0;
         en_s1_q  <= 1'b0;
         en_s2_q  <= 1'b0;
      end else begin
         a2b_s1_q <= a2b;
         a2b_s2_q <= a2b_s1_q;
         en_s1_q  <= en;
         en_s2_q  <= en_s1_q;
      end
   end

   assign a2b_c = a2b_s2_q;
   assign en_c  = en_s2_q;
`else
   assign a2b_c = a2b;
   assign en_c  = en;
`endif

   for (genvar i = 0; i < N; i++) begin : g_ch
      la_ioshortbus_ch #(
         .TURN (TURN)
      ) u_ch (
         .clk    (clk),
         .nreset (nreset),
         .a      (a[i]),
         .b      (b[i]),
         .a2b    (a2b_c[i]),
         .en     (en_c),
         .dir    (dir[i]),
         .act    (act[i]),
         .busy   (busy[i])
      );
   end

endmodule

// File: tb/tb_la_ioshortbus.sv
// Directed and randomised checks of la_ioshortbus (N=8, TURN=2), with pulldowns
// on every net so a released wire reads 0.
module tb_la_ioshortbus;

   localparam int N    = 8;
   localparam int TURN = 2;
`ifdef LA_IOSHORTBUS_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic         clk = 1'b0;
   logic         nreset = 1'b0;
   logic         en = 1'b0;
   logic [N-1:0] a2b = '0;
   logic [N-1:0] a_drv = '0, b_drv = '0;
   logic [N-1:0] a_oe = '0, b_oe = '0;
   wire  [N-1:0] a_net, b_net;
   logic [N-1:0] dir, act, busy;

   int passed = 0;
   int total  = 0;

   for (genvar i = 0; i < N; i++) begin : g_drv
      assign a_net[i] = a_oe[i] ? a_drv[i] : 1'bz;
      assign b_net[i] = b_oe[i] ? b_drv[i] : 1'bz;
      pulldown (a_net[i]);
      pulldown (b_net[i]);
   end

   always #5 clk = ~clk;

   la_ioshortbus #(.N(N), .TURN(TURN)) dut (
      .clk    (clk),
      .nreset (nreset),
      .a      (a_net),
      .b      (b_net),
      .a2b    (a2b),
      .en     (en),
      .dir    (dir),
      .act    (act),
      .busy   (busy)
   );

   // reference model: 0 OFF, 1 TURN, 2 A2B, 3 B2A
   int           m_st [N];
   int           m_cnt[N];
   logic [N-1:0] m_dir;
   logic [N-1:0] m_a2b_s1, m_a2b_s2;
   logic         m_en_s1, m_en_s2;

   always @(posedge clk or negedge nreset) begin : model
      logic [N-1:0] ra;
      logic         re;
      if (!nreset) begin
         for (int i = 0; i < N; i++) begin
            m_st[i]  <= 0;
            m_cnt[i] <= 0;
         end
         m_dir    <= '0;
         m_a2b_s1 <= '0;
         m_a2b_s2 <= '0;
         m_en_s1  <= 1'b0;
         m_en_s2  <= 1'b0;
      end else begin
`ifdef LA_IOSHORTBUS_SYNC_EN
         ra = m_a2b_s2;
         re = m_en_s2;
`else
         ra = a2b;
         re = en;
`endif
         m_a2b_s1 <= a2b;
         m_a2b_s2 <= m_a2b_s1;
         m_en_s1  <= en;
         m_en_s2  <= m_en_s1;
         for (int i = 0; i < N; i++) begin
            if (!re) begin
               m_st[i]  <= 0;
               m_cnt[i] <= 0;
            end else if (m_st[i] == 0) begin
               m_st[i]  <= 1;
               m_cnt[i] <= TURN - 1;
            end else if (m_st[i] == 1) begin
               if (m_cnt[i] > 0) m_cnt[i] <= m_cnt[i] - 1;
               else begin
                  m_st[i]  <= ra[i] ? 2 : 3;
                  m_dir[i] <= ra[i];
               end
            end else if ((m_st[i] == 2) != ra[i]) begin
               m_st[i]  <= 1;
               m_cnt[i] <= TURN - 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_oe  = 8'hFF;
      a_drv = 8'hFF;
      #2;
      total++; if ({act, busy, dir} !== 24'h0) $display("FAIL reset_outs act/busy/dir=%h exp=%h", {act, busy, dir}, 24'h0); else passed++;
      total++; if (b_net !== 8'h00) $display("FAIL reset_release b=%h exp=%h", b_net, 8'h00); else passed++;
   endtask

   task automatic test_enable();
      @(posedge clk); #1;
      nreset = 1'b1;
      en     = 1'b1;
      a2b    = 8'hFF;
      a_drv  = 8'hA5;
      repeat (LAT) begin
         step();
         total++; if (busy !== 8'h00) $display("FAIL en_latency busy=%h exp=%h", busy, 8'h00); else passed++;
      end
      step();
      total++; if (busy !== 8'hFF) $display("FAIL en_busy1 busy=%h exp=%h", busy, 8'hFF); else passed++;
      total++; if (b_net !== 8'h00) $display("FAIL en_turn_b b=%h exp=%h", b_net, 8'h00); else passed++;
      step();
      total++; if ({busy, act} !== 16'hFF00) $display("FAIL en_busy2 busy/act=%h exp=%h", {busy, act}, 16'hFF00); else passed++;
      step();
      total++; if ({busy, act, dir} !== 24'h00FFFF) $display("FAIL en_commit busy/act/dir=%h exp=%h", {busy, act, dir}, 24'h00FFFF); else passed++;
      total++; if (b_net !== 8'hA5) $display("FAIL en_data b=%h exp=%h", b_net, 8'hA5); else passed++;
   endtask

   task automatic test_turn_ch3();
      a2b[3]  = 1'b0;
      a_oe[3] = 1'b0;
      repeat (LAT) step();
      step();
      total++; if ({busy, act} !== 16'h08F7) $display("FAIL ch3_turn busy/act=%h exp=%h", {busy, act}, 16'h08F7); else passed++;
      b_oe[3]  = 1'b1;
      b_drv[3] = 1'b1;
      #1;
      total++; if (a_net[3] !== 1'b0) $display("FAIL ch3_release1 a3=%b exp=%b", a_net[3], 1'b0); else passed++;
      total++; if ((b_net & 8'hF7) !== 8'hA5) $display("FAIL ch3_others b=%h exp=%h", b_net & 8'hF7, 8'hA5); else passed++;
      step();
      total++; if ({busy, a_net[3]} !== 9'h010) $display("FAIL ch3_release2 busy/a3=%h exp=%h", {busy, a_net[3]}, 9'h010); else passed++;
      step();
      total++; if ({busy, act, dir} !== 24'h00FFF7) $display("FAIL ch3_commit busy/act/dir=%h exp=%h", {busy, act, dir}, 24'h00FFF7); else passed++;
      total++; if (a_net[3] !== 1'b1) $display("FAIL ch3_data a3=%b exp=%b", a_net[3], 1'b1); else passed++;
   endtask

   task automatic test_toggle_ch0();
      a2b[0]  = 1'b0;
      a_oe[0] = 1'b0;
      step();
      a2b[0] = 1'b1;
      step();
      a2b[0] = 1'b0;
      repeat (LAT) step();
      total++; if ({busy, act} !== 16'h01FE) $display("FAIL ch0_midturn busy/act=%h exp=%h", {busy, act}, 16'h01FE); else passed++;
      b_oe[0]  = 1'b1;
      b_drv[0] = 1'b1;
      step();
      total++; if ({busy, act, dir} !== 24'h00FFF6) $display("FAIL ch0_commit busy/act/dir=%h exp=%h", {busy, act, dir}, 24'h00FFF6); else passed++;
      total++; if (a_net[0] !== 1'b1) $display("FAIL ch0_data a0=%b exp=%b", a_net[0], 1'b1); else passed++;
      step();
      total++; if ({busy, act, dir} !== 24'h00FFF6) $display("FAIL ch0_hold busy/act/dir=%h exp=%h", {busy, act, dir}, 24'h00FFF6); else passed++;
   endtask

   task automatic test_en_drop();
      a2b[5]  = 1'b0;
      a_oe[5] = 1'b0;
      step();
      en = 1'b0;
      repeat (LAT) step();
      total++; if ({busy, act} !== 16'h20DF) $display("FAIL drop_midturn busy/act=%h exp=%h", {busy, act}, 16'h20DF); else passed++;
      step();
      total++; if ({busy, act} !== 16'h0000) $display("FAIL drop_off busy/act=%h exp=%h", {busy, act}, 16'h0000); else passed++;
      total++; if ({a_net, b_net} !== 16'h8409) $display("FAIL drop_release a/b=%h exp=%h", {a_net, b_net}, 16'h8409); else passed++;
   endtask

   task automatic test_async_reset();
      en    = 1'b1;
      a2b   = 8'hFF;
      a_oe  = 8'hFF;
      b_oe  = 8'h00;
      a_drv = 8'hFF;
      repeat (LAT + TURN + 1) step();
      total++; if ({act, b_net} !== 16'hFFFF) $display("FAIL rst_pre act/b=%h exp=%h", {act, b_net}, 16'hFFFF); else passed++;
      #3;
      nreset = 1'b0;
      #1;
      total++; if ({act, busy, dir} !== 24'h0) $display("FAIL rst_async act/busy/dir=%h exp=%h", {act, busy, dir}, 24'h0); else passed++;
      total++; if (b_net !== 8'h00) $display("FAIL rst_async_b b=%h exp=%h", b_net, 8'h00); else passed++;
   endtask

   task automatic test_random();
      logic [N-1:0] m_act, m_busy, exp_a, exp_b;
      int           ctl_fail = 0;
      int           dat_fail = 0;
      #3;
      nreset = 1'b1;
      a_oe   = '0;
      b_oe   = '0;
      step();
      for (int it = 0; it < 1000; it++) begin
         a_drv = 8'($urandom_range(0, 255));
         b_drv = 8'($urandom_range(0, 255));
         for (int i = 0; i < N; i++) begin
            a_oe[i]   = (m_st[i] == 2);
            b_oe[i]   = (m_st[i] == 3);
            m_act[i]  = (m_st[i] >= 2);
            m_busy[i] = (m_st[i] == 1);
            exp_a[i]  = (m_st[i] == 2) ? a_drv[i] : (m_st[i] == 3) ? b_drv[i] : 1'b0;
            exp_b[i]  = (m_st[i] == 2) ? a_drv[i] : (m_st[i] == 3) ? b_drv[i] : 1'b0;
         end
         #1;
         total++;
         if ({act, busy, dir & act} !== {m_act, m_busy, m_dir & m_act}) begin
            if (ctl_fail < 10) $display("FAIL rnd_ctl it=%0d act/busy/dir=%h exp=%h", it, {act, busy, dir & act}, {m_act, m_busy, m_dir & m_act});
            ctl_fail++;
         end else passed++;
         total++;
         if ({a_net, b_net} !== {exp_a, exp_b}) begin
            if (dat_fail < 10) $display("FAIL rnd_data it=%0d a/b=%h exp=%h", it, {a_net, b_net}, {exp_a, exp_b});
            dat_fail++;
         end else passed++;
         a2b = a2b ^ (8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
         en  = ($urandom_range(0, 49) != 0);
         step();
      end
   endtask

   initial begin
      test_reset();
      test_enable();
      test_turn_ch3();
      test_toggle_ch0();
      test_en_drop();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/la_ioshortbus.md
# la_ioshortbus

Parametrised, multi-channel successor to the single-wire short: connects N pairs of bidirectional wires `a[i]`/`b[i]`, each with its own requested direction. A per-channel state machine enforces break-before-make: on every direction change both sides are released for a programmable number of cycles before the new driver is enabled. It sits between pad-side and core-side nets in IO rings and test harnesses, and works unchanged in Verilator because at most one side of each channel is ever driven.

## Interface
- `N`, default 8: number of channels, must be at least 1.
- `TURN`, default 2: number of turnaround cycles during which both sides are hi-Z, must be at least 1.
- `clk`  input  1  clock; the block has one clock.
- `nreset`  input  1  asynchronous, active-low reset.
- `a`  inout  N  side A nets.
- `b`  inout  N  side B nets.
- `a2b`  input  N  requested direction per channel: 1 means A drives B, 0 means B drives A.
- `en`  input  1  global enable; 0 forces every channel to OFF.
- `dir`  output  N  committed direction; only meaningful when `act[i]` is 1.
- `act`  output  N  channel is committed and driving.
- `busy`  output  N  channel is in turnaround.

## Operation
- Per-channel state machine with states OFF, TURN, A2B and B2A. Each channel has a down-counter of width `$clog2(TURN+1)`.
- Net drive per state:
  - A2B: `b[i] = a[i]`.
  - B2A: `a[i] = b[i]`.
  - OFF and TURN: both `a[i]` and `b[i]` are released (hi-Z).
  - The data path is combinational from the registered state. Two drivers on one channel can never both be enabled.
- Transitions, evaluated at each rising edge of `clk`. `en` = 0 has priority over everything else.
  - Any state, `en` = 0: go to OFF and clear the counter.
  - OFF, `en` = 1: go to TURN and load the counter with `TURN-1`.
  - A2B with `a2b[i]` = 0, or B2A with `a2b[i]` = 1: go to TURN and load the counter with `TURN-1`.
  - A2B or B2A with `a2b[i]` equal to `dir[i]`: hold.
  - TURN with counter > 0: decrement the counter.
  - TURN with counter = 0: go to A2B if `a2b[i]` is 1, else B2A. Set `dir[i]` to `a2b[i]` at that same edge.
- Requests that toggle during TURN do not restart the counter. The value of `a2b[i]` at the final TURN edge wins. If that value equals the old direction, the channel still spends the full TURN cycles released.
- Outputs: `act[i]` is 1 only in A2B or B2A. `busy[i]` is 1 only in TURN.
- Channels are fully independent apart from the shared `en`.
- Reset values: state OFF, `dir` = 0, `act` = 0, `busy` = 0, counter = 0, all nets released.
- Reset asserted mid-turnaround or mid-transfer: the channel releases both sides immediately (asynchronously). There is no drain.

## Timing
- A direction request or enable sampled at edge E0 gives: `busy` high from E0 for exactly TURN cycles; new driver enabled and `act` high after edge E0+TURN.
- Enable to first drive: TURN+1 edges from the edge where `en` is first sampled high.
- `en` falling sampled at edge E: all nets are released after E, with no turnaround.
- The data path has zero cycles of latency while a channel is committed.
- Reset deassertion: the first possible state change is at the first edge after `nreset` is sampled high.

## Configuration
- Macro: `LA_IOSHORTBUS_SYNC_EN`.
- Defined: `a2b` and `en` each pass through a two-flop synchroniser clocked by `clk` and reset to 0. All timings above gain two cycles of input latency. The control inputs may then be asynchronous to `clk`.
- Undefined: `a2b` and `en` are used directly and must be synchronous to `clk`.

## Structure
- Package `la_ioshortbus_pkg` holds the state enum typedef (OFF, TURN, A2B, B2A) and the function that computes the counter width.
- Sub-module `la_ioshortbus_ch` contains one channel: its state machine, counter, and tristate assigns for `a[i]` and `b[i]`.
- The top instantiates N copies of `la_ioshortbus_ch` in a generate loop, plus the optional synchroniser.

## Test plan
- Reset then `en` = 1, `a2b` = all ones, N = 8, TURN = 2 → `busy` = 8'hFF for 2 cycles, then `act` = 8'hFF, `dir` = 8'hFF; driving `a` = 8'hA5 gives `b` = 8'hA5.
- Channel 3 committed A2B, `a2b[3]` set to 0 → `a[3]` and `b[3]` both Z for exactly 2 cycles, then `a[3]` follows `b[3]`; all other channels are undisturbed.
- During TURN, toggle `a2b[0]` 0→1→0 with the last value 0 at the final edge → commits B2A; the counter is never reloaded.
- `en` dropped mid-TURN and also while committed → all channels are OFF after the next edge, with nets Z and `act` = `busy` = 0.
- `nreset` asserted asynchronously mid-transfer → nets Z and outputs 0 before the next clock edge.
- With `LA_IOSHORTBUS_SYNC_EN` defined, the first scenario shows `act` rising 2 cycles later; a contention checker reports no cycle in which both sides of any channel are driven across 1000 random `a2b` toggles.
